// File: rtl/strhw_common_types.sv
// Shared types and constants for the Streebog message front-end.
// Also holds the elaboration-time word-width legality check.
package strhw_common_types;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [511:0] uint512;

  localparam uint512 PAD_ONLY_BLOCK = 512'h1;

  function automatic bit legal_word_w(input int w);
    return (w == 8) || (w == 16) || (w == 32) || (w == 64) ||
           (w == 128) || (w == 256) || (w == 512);
  endfunction

endpackage

// File: rtl/strhw_byte_pad.sv
// Combinational last-word padder: keeps the low nbytes bytes, zeroes the rest and
// sets the marker bit at 8*nbytes (bit WORD_W when the word is full).
module strhw_byte_pad #(
  parameter int WORD_W = 64
) (
  input  logic [WORD_W-1:0]          word,
  input  logic [$clog2(WORD_W/8):0]  nbytes,
  output logic [WORD_W:0]            padded
);

  localparam int NB_W = $clog2(WORD_W/8) + 1;

  always_comb begin
    padded = '0;
    for (int i = 0; i < WORD_W/8; i++) begin
      if (NB_W'(i) < nbytes) padded[8*i +: 8] = word[8*i +: 8];
    end
    padded = padded | ((WORD_W+1)'(1) << {nbytes, 3'b000});
  end

endmodule

// File: rtl/strhw_msg_padder.sv
// Packs a WORD_W-bit byte-aligned message stream into 512-bit Streebog blocks and
// applies the 0..0 || 1 || M padding; one registered block presented at a time.
module strhw_msg_padder
  import strhw_common_types::*;
#(
  parameter int WORD_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_data,
  input  logic                       in_last,
  input  logic [$clog2(WORD_W/8):0]  in_nbytes,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [511:0]               out_data,
  output logic [9:0]                 out_bits,
  output logic                       out_last
);

  localparam int WORDS = 512 / WORD_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WORDS - 1);

  if (!legal_word_w(WORD_W)) begin : g_bad_width
    $error("strhw_msg_padder: illegal WORD_W %0d", WORD_W);
  end

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  uint512           data_q, data_d;
  logic [9:0]       bits_q, bits_d;
  logic             last_q, last_d;
  logic             pad_q, pad_d;

  logic [WORD_W:0]  pad_word;
  logic [9:0]       shamt;
  logic [10:0]      msg_bits;
  uint512           ins;
  logic             accept;
  logic             blk_full;

  strhw_byte_pad #(.WORD_W(WORD_W)) u_byte_pad (
    .word   (in_data),
    .nbytes (in_nbytes),
    .padded (pad_word)
  );

  assign in_ready = ((state_q == CLEAR) || (state_q == BUSY)) && !rst;
  assign accept   = in_valid && in_ready;
  assign blk_full = (idx_q == IDX_MAX);
  assign shamt    = 10'(idx_q) * 10'(WORD_W);
  assign msg_bits = 11'(shamt) + 11'({in_nbytes, 3'b000});

  // A marker that lands on bit 512 (exactly full block) falls off here; pad_pending covers it.
  assign ins = in_last ? (512'(pad_word) << shamt) : (512'(in_data) << shamt);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    bits_d  = bits_q;
    last_d  = last_q;
    pad_d   = pad_q;
    case (state_q)
      CLEAR, BUSY: begin
        if (accept) begin
          data_d = data_q | ins;
          idx_d  = blk_full ? '0 : idx_q + IDX_W'(1);
          if (in_last && (msg_bits < 11'd512)) begin
            state_d = DONE;
            bits_d  = msg_bits[9:0];
            last_d  = 1'b1;
            idx_d   = '0;
          end else if (in_last || blk_full) begin
            state_d = READY;
            bits_d  = 10'd512;
            last_d  = 1'b0;
            pad_d   = in_last;
            idx_d   = '0;
          end else begin
            state_d = BUSY;
          end
        end
      end
      READY: begin
        if (out_ready) begin
          if (pad_q) begin
            state_d = DONE;
            data_d  = PAD_ONLY_BLOCK;
            bits_d  = 10'd0;
            last_d  = 1'b1;
            pad_d   = 1'b0;
          end else begin
            state_d = CLEAR;
            data_d  = '0;
            bits_d  = 10'd0;
            last_d  = 1'b0;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = CLEAR;
          data_d  = '0;
          bits_d  = 10'd0;
          last_d  = 1'b0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      data_q  <= '0;
      bits_q  <= 10'd0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      bits_q  <= bits_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
    end
  end

  assign out_valid = (state_q == READY) || (state_q == DONE);
  assign out_data  = data_q;
  assign out_bits  = bits_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_strhw_msg_padder.sv
// Bench for strhw_msg_padder: directed tests on a 64-bit instance plus a 100-byte
// message on every other legal width, all checked against a byte-level block model.
module tb_strhw_msg_padder;

  typedef struct packed {
    logic [511:0] data;
    logic [9:0]   bits;
    logic         last;
  } blk_t;
  typedef logic [7:0] bq_t[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Message of n bytes -> n/64 full blocks, then one final block of the n%64 leftover bytes
  // with a 1 appended directly above them.
  function automatic int model_nblk(input int n);
    return n / 64 + 1;
  endfunction

  function automatic blk_t model_blk(input bq_t msg, input int k);
    blk_t b;
    int n, full, r;
    n = msg.size();
    full = n / 64;
    b.data = '0;
    if (k < full) begin
      for (int i = 0; i < 64; i++) b.data[8*i +: 8] = msg[64*k + i];
      b.bits = 10'd512;
      b.last = 1'b0;
    end else begin
      r = n - 64 * full;
      for (int i = 0; i < r; i++) b.data[8*i +: 8] = msg[64*k + i];
      b.data[8*r] = 1'b1;
      b.bits = 10'(8 * r);
      b.last = 1'b1;
    end
    return b;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main 64-bit instance ----------------
  logic         rst, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [63:0]  in_data;
  logic [3:0]   in_nbytes;
  logic [511:0] out_data;
  logic [9:0]   out_bits;
  blk_t         exp_q[$];

  strhw_msg_padder #(.WORD_W(64)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bits(out_bits), .out_last(out_last)
  );

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_block", out_valid, 1'b0);
      else begin
        chk("blk_data", out_data, exp_q[0].data);
        chk("blk_bits", out_bits, exp_q[0].bits);
        chk("blk_last", out_last, exp_q[0].last);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    logic rdy;
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb;
    forever begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk);
      if (rdy) break;
      t++;
      if (t > 200) begin chk("in_ready_timeout", rdy, 1'b1); break; end
    end
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input bq_t msg, input bit extra_empty);
    int n, nw, idx;
    logic [63:0] d;
    logic last;
    n = msg.size();
    for (int k = 0; k < model_nblk(n); k++) exp_q.push_back(model_blk(msg, k));
    nw = (n + 7) / 8;
    if (nw == 0 && !extra_empty) nw = 1;
    for (int w = 0; w < nw; w++) begin
      for (int j = 0; j < 8; j++) begin
        idx = 8 * w + j;
        d[8*j +: 8] = (idx < n) ? msg[idx] : 8'hFF;
      end
      last = (w == nw - 1) && !extra_empty;
      send_word(d, last, last ? 4'(n - 8 * w) : 4'd8);
    end
    if (extra_empty) send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 500) begin @(posedge clk); t++; end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // ---------------- one instance per other legal width ----------------
  for (genvar gi = 0; gi < 6; gi++) begin : g_w
    localparam int W   = 8 << ((gi < 3) ? gi : gi + 1);
    localparam int BPW = W / 8;
    localparam int NBW = $clog2(BPW) + 1;
    logic           g_rst, g_iv, g_ir, g_il, g_ov, g_or, g_ol, g_done;
    logic [W-1:0]   g_id;
    logic [NBW-1:0] g_nb;
    logic [511:0]   g_od;
    logic [9:0]     g_ob;
    bq_t            g_msg;
    int             g_k, g_nblk;
    blk_t           g_e;

    strhw_msg_padder #(.WORD_W(W)) u_dut (
      .clk(clk), .rst(g_rst), .in_valid(g_iv), .in_ready(g_ir), .in_data(g_id),
      .in_last(g_il), .in_nbytes(g_nb), .out_valid(g_ov), .out_ready(g_or),
      .out_data(g_od), .out_bits(g_ob), .out_last(g_ol)
    );

    always @(negedge clk) begin
      if (!g_rst && g_ov) begin
        if (g_k >= g_nblk) chk($sformatf("w%0d_extra_block", W), g_ov, 1'b0);
        else begin
          g_e = model_blk(g_msg, g_k);
          chk($sformatf("w%0d_data", W), g_od, g_e.data);
          chk($sformatf("w%0d_bits", W), g_ob, g_e.bits);
          chk($sformatf("w%0d_last", W), g_ol, g_e.last);
          if (g_or) g_k++;
        end
      end
    end

    initial begin
      int n, nw, idx, t;
      logic rdy;
      g_rst = 1'b1; g_iv = 1'b0; g_id = '0; g_il = 1'b0; g_nb = '0; g_or = 1'b1;
      g_k = 0; g_nblk = 0; g_done = 1'b0;
      repeat (2) @(posedge clk);
      #1 g_rst = 1'b0;
      for (int m = 0; m < 2; m++) begin
        g_msg.delete();
        if (m == 1) for (int i = 0; i < 100; i++) g_msg.push_back(8'($urandom));
        n = g_msg.size();
        g_k = 0;
        g_nblk = model_nblk(n);
        if (m == 1) begin
          g_e = model_blk(g_msg, 1);
          chk($sformatf("w%0d_model_bits288", W), g_e.bits, 10'd288);
          chk($sformatf("w%0d_model_bit288", W), g_e.data[288], 1'b1);
        end else g_or = 1'b0;
        nw = (n + BPW - 1) / BPW;
        if (nw == 0) nw = 1;
        for (int w = 0; w < nw; w++) begin
          for (int j = 0; j < BPW; j++) begin
            idx = BPW * w + j;
            g_id[8*j +: 8] = (idx < n) ? g_msg[idx] : 8'hFF;
          end
          g_il = (w == nw - 1);
          g_nb = g_il ? NBW'(n - BPW * w) : NBW'(BPW);
          g_iv = 1'b1;
          t = 0;
          forever begin
            @(negedge clk); rdy = g_ir;
            @(posedge clk);
            if (rdy) break;
            t++;
            if (t > 200) begin chk($sformatf("w%0d_in_ready_timeout", W), rdy, 1'b1); break; end
          end
          #1 g_iv = 1'b0; g_il = 1'b0;
        end
        if (m == 0) begin
          repeat (3) begin
            @(negedge clk);
            chk($sformatf("w%0d_empty_in_ready_held", W), g_ir, 1'b0);
          end
          @(posedge clk); #1 g_or = 1'b1;
        end
        t = 0;
        while (g_k < g_nblk && t < 1000) begin @(posedge clk); t++; end
        chk($sformatf("w%0d_drain", W), g_k, g_nblk);
        @(posedge clk); #1;
      end
      g_done = 1'b1;
    end
  end

  // ---------------- directed sequence on the 64-bit instance ----------------
  initial begin
    bq_t msg1, msg2, msg5, msg6, msg7, msg0;
    logic [511:0] lit;
    blk_t b;
    int t;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_nbytes = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_bits", out_bits, 10'd0);
    chk("rst_out_last", out_last, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // 64-byte message: full block then the pad-only block with no idle cycle between.
    for (int i = 0; i < 64; i++) msg1.push_back(8'(i));
    for (int k = 0; k < 8; k++)
      lit[64*k +: 64] = 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
    b = model_blk(msg1, 0);
    chk("model_full_data", b.data, lit);
    chk("model_full_bits", b.bits, 10'd512);
    b = model_blk(msg1, 1);
    chk("model_pad_data", b.data, 512'h1);
    chk("model_pad_bits", b.bits, 10'd0);
    send_msg(msg1, 1'b0);
    @(negedge clk);
    chk("full_vld", out_valid, 1'b1);
    chk("full_bits", out_bits, 10'd512);
    @(negedge clk);
    chk("pad_back_to_back_vld", out_valid, 1'b1);
    chk("pad_back_to_back_last", out_last, 1'b1);
    wait_drain();

    // Single 3-byte word; upper bytes of the bus are 0xFF and must be masked.
    msg2 = '{8'hEF, 8'hCD, 8'hAB};
    b = model_blk(msg2, 0);
    chk("model_short_data", b.data, 512'h01ABCDEF);
    chk("model_short_bits", b.bits, 10'd24);
    send_msg(msg2, 1'b0);
    wait_drain();

    // Empty message while the sink stalls.
    out_ready = 1'b0;
    b = model_blk(msg0, 0);
    chk("model_empty_data", b.data, 512'h1);
    send_msg(msg0, 1'b0);
    repeat (3) begin @(negedge clk); chk("empty_in_ready_held", in_ready, 1'b0); end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain();

    // Stall a full block for 5 cycles; pad block follows right after release.
    out_ready = 1'b0;
    send_msg(msg1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_vld", out_valid, 1'b1);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_pad_vld", out_valid, 1'b1);
    chk("stall_pad_last", out_last, 1'b1);
    chk("stall_pad_bits", out_bits, 10'd0);
    wait_drain();

    // Reset after 3 words, then a 63-byte message must come out clean.
    for (int w = 0; w < 3; w++) send_word({$urandom, $urandom}, 1'b0, 4'd8);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 63; i++) msg5.push_back(8'($urandom));
    send_msg(msg5, 1'b0);
    wait_drain();
    repeat (3) @(negedge clk);
    chk("midrst_no_extra_block", out_valid, 1'b0);

    // 16 bytes followed by an empty last word at index 2.
    for (int i = 0; i < 16; i++) msg6.push_back(8'($urandom));
    b = model_blk(msg6, 0);
    chk("model_tail_bits", b.bits, 10'd128);
    @(posedge clk); #1;
    send_msg(msg6, 1'b1);
    wait_drain();

    // 100-byte random message.
    for (int i = 0; i < 100; i++) msg7.push_back(8'($urandom));
    send_msg(msg7, 1'b0);
    wait_drain();

    t = 0;
    while (!(g_w[0].g_done && g_w[1].g_done && g_w[2].g_done && g_w[3].g_done &&
             g_w[4].g_done && g_w[5].g_done) && t < 20000) begin
      @(posedge clk); t++;
    end
    chk("width_sweep_done", {g_w[0].g_done, g_w[1].g_done, g_w[2].g_done,
                             g_w[3].g_done, g_w[4].g_done, g_w[5].g_done}, 6'h3F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/strhw_msg_padder.md
# strhw_msg_padder

Parametrised message front-end for the Streebog (GOST 34.11-2018) core. It accepts a byte-aligned message as a stream of WORD_W-bit words and packs them into 512-bit blocks. It applies the standard padding m = 0…0 ‖ 1 ‖ M to the final partial block and emits each block with its valid-bit count and a last flag. It sits between the host-side stream interface and the compression/counter datapath, replacing fixed-width block loading.

## Interface
- WORD_W, 64, input word width in bits; legal values are 8, 16, 32, 64, 128, 256 and 512. Any other value is an elaboration error.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid && in_ready.
- in_data  in  WORD_W  message word; byte 0 is in bits [7:0].
- in_last  in  1  final word of message.
- in_nbytes  in  $clog2(WORD_W/8)+1  valid low bytes in a last word (0..WORD_W/8). Ignored unless in_last.
- out_valid  out  1  block valid.
- out_ready  in  1  block consumed when out_valid && out_ready.
- out_data  out  512  block, little-endian (word k at bits [k*WORD_W +: WORD_W]).
- out_bits  out  10  message bits in block (0..512).
- out_last  out  1  final (padded) block of message.

## Operation
- The FSM uses the shared state_t:
  - CLEAR: accumulator empty.
  - BUSY: accumulator partially filled.
  - READY: non-final full block presented.
  - DONE: final block presented.
- in_ready = (state==CLEAR || state==BUSY) && !rst. No input is accepted while a block is presented.
- Word index counter: width log2(512/WORD_W), with 0 meaning no counter when WORD_W=512. It increments per accepted word and wraps to 0 when a block is completed.
- Non-last word accepted:
  - It is written at the current index.
  - If this completes the block: go to READY with out_bits=512 and out_last=0.
  - Otherwise the state is BUSY.
- Last word accepted with nbytes=b. The message bit count in the block is L = index*WORD_W + 8b.
  - If L<512: bytes ≥b of the word are zeroed, bit L is set to 1, all higher bits are 0. out_bits=L, out_last=1, state DONE.
  - If L==512: present the full block (out_bits=512, out_last=0) in READY and set pad_pending.
- READY + out_ready:
  - If pad_pending: load out_data=512'h1, out_bits=0, out_last=1, clear pad_pending, state DONE.
  - Otherwise clear the accumulator and go to CLEAR.
- DONE + out_ready: clear the accumulator and go to CLEAR, ready for the next message.
- Empty message (in_last with b=0 at index 0) gives out_data=512'h1, out_bits=0, out_last=1.
- in_nbytes=0 on a last word at a nonzero index is legal. Padding then starts at that word's first bit.
- Accumulator bytes beyond the written region are always 0; clearing happens on block hand-off, not on write.

## Timing
- Reset values: state=CLEAR, out_valid=0, out_data=0, out_bits=0, out_last=0, pad_pending=0, index=0. in_ready=0 while rst is high and 1 from the first cycle after release.
- Async reset mid-block or mid-handshake discards all partial data. There is no output on release.
- Latency: the word completing a block is accepted at edge t; out_valid is high after edge t, with out_data registered.
- out_data, out_bits and out_last are stable while out_valid && !out_ready.
- Pad block follows its full block with zero idle cycles if out_ready is held high.
- Throughput: 512/WORD_W input cycles plus 1 hand-off cycle per block. With WORD_W=512 this is one block every 2 cycles.

## Structure
- state_t, uint512 and the WORD_W-independent constant PAD_ONLY_BLOCK = 512'h1 live in strhw_common_types.
- Add a localparam legal-width check function to the package.
- One natural sub-module: strhw_byte_pad, a combinational unit (word, nbytes) → masked word with marker bit. It is instantiated once.

## Test plan
- WORD_W=64: 8 words 0x0706050403020100+k·0x0808080808080808, last on the 8th with nbytes=8 → full block (bits=512, last=0), then 512'h1 (bits=0, last=1).
- WORD_W=64: a single last word with nbytes=3 and data 0xFFFFFFFFFFABCDEF → out_data=0x01ABCDEF, bits=24, last=1.
- WORD_W=8: empty message (in_last, nbytes=0) → out_data=512'h1, bits=0, last=1. in_ready stays low until out_ready.
- out_ready held low for 5 cycles on a full block → outputs stable and in_ready=0. The pad block appears the cycle after out_ready rises.
- rst pulsed after 3 of 8 words → out_valid=0. The next 8-word message produces exactly one correct block with no residue of the earlier words.
- Each legal WORD_W: a 100-byte random message → 1 block of 512 bits plus 1 final block with bits=288 and bit 288 set, checked against a reference model.
